// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: block constants, GF(2^8) arithmetic over 0x11B,
// inverse S-box and the inverse-cipher control states.
package aes128_pkg;

  localparam int unsigned AES128_NUM_ROUNDS = 10;
  localparam int unsigned AES128_BLK_W      = 128;

  typedef enum logic {
    INV_IDLE = 1'b0,
    INV_BUSY = 1'b1
  } inv_state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  // Undo the affine map first, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

endpackage

// File: rtl/aes128_inv_cipher_core_if.sv
// Signal bundle for the AES-128 inverse cipher core: host side (master) and core side (slave).
interface aes128_inv_cipher_core_if;
  import aes128_pkg::*;

  logic [AES128_BLK_W-1:0] cipher_text;
  logic [AES128_BLK_W-1:0] last_key;
  logic [AES128_BLK_W-1:0] round_key;
  logic                    decipher_en;
  logic [AES128_BLK_W-1:0] plain_text;
  logic                    decipher_ready;
  logic [3:0]              round_num;
  logic                    rkey_en;
  logic                    decipher_done;

  modport master (
    output cipher_text, last_key, round_key, decipher_en,
    input  plain_text, decipher_ready, round_num, rkey_en, decipher_done
  );

  modport slave (
    input  cipher_text, last_key, round_key, decipher_en,
    output plain_text, decipher_ready, round_num, rkey_en, decipher_done
  );
endinterface

// File: rtl/aes128_inv_mixcol.sv
// InvMixColumns for one 32-bit column (byte0 in [31:24]), purely combinational.
module aes128_inv_mixcol
  import aes128_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    a0 = col_i[31:24];
    a1 = col_i[23:16];
    a2 = col_i[15:8];
    a3 = col_i[7:0];
    col_o[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    col_o[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    col_o[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    col_o[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end
endmodule

// File: rtl/aes128_inv_cipher_core.sv
// Iterative AES-128 inverse cipher, one round per cycle, round keys supplied externally.
// Optional AES128_INV_DONE_PULSE_EN adds a one-cycle decipher_done pulse on completion.
module aes128_inv_cipher_core
  import aes128_pkg::*;
(
  input  logic                    clk_sys,
  input  logic                    rst,
  input  logic [AES128_BLK_W-1:0] cipher_text,
  input  logic [AES128_BLK_W-1:0] last_key,
  input  logic [AES128_BLK_W-1:0] round_key,
  input  logic                    decipher_en,
  output logic [AES128_BLK_W-1:0] plain_text,
  output logic                    decipher_ready,
  output logic [3:0]              round_num,
  output logic                    rkey_en
`ifdef AES128_INV_DONE_PULSE_EN
  ,
  output logic                    decipher_done
`endif
);
  inv_state_e              state_q, state_d;
  logic [3:0]              round_q, round_d;
  logic [AES128_BLK_W-1:0] data_q, data_d;
  logic [AES128_BLK_W-1:0] sub_sr, ark, mix;
  int unsigned             src;

  // Byte i sits at row i%4, column i/4; row r takes its byte from column (c-r) mod 4.
  always_comb begin
    sub_sr = '0;
    src    = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      src = 4 * (((i >> 2) + 4 - (i & 3)) & 3) + (i & 3);
      sub_sr[127 - 8*i -: 8] = inv_sbox(data_q[127 - 8*src -: 8]);
    end
    ark = sub_sr ^ round_key;
  end

  for (genvar c = 0; c < 4; c++) begin : gen_mix
    aes128_inv_mixcol u_mix (
      .col_i (ark[127 - 32*c -: 32]),
      .col_o (mix[127 - 32*c -: 32])
    );
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= INV_IDLE;
      round_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    data_d  = data_q;
    case (state_q)
      INV_IDLE: begin
        if (decipher_en) begin
          data_d  = cipher_text ^ last_key;
          round_d = 4'(AES128_NUM_ROUNDS - 1);
          state_d = INV_BUSY;
        end
      end
      INV_BUSY: begin
        if (round_q == 4'd0) begin
          data_d  = ark;
          state_d = INV_IDLE;
        end else begin
          data_d  = mix;
          round_d = round_q - 4'd1;
        end
      end
      default: state_d = INV_IDLE;
    endcase
  end

  always_comb begin
    decipher_ready = (state_q == INV_IDLE);
    rkey_en        = (state_q == INV_BUSY);
    plain_text     = data_q;
    round_num      = round_q;
  end

`ifdef AES128_INV_DONE_PULSE_EN
  logic done_q, done_d;

  always_comb done_d = (state_q == INV_BUSY) && (round_q == 4'd0);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= done_d;
  end

  assign decipher_done = done_q;
`endif
endmodule

// File: tb/tb_aes128_inv_cipher_core.sv
// Scoreboard bench for aes128_inv_cipher_core using FIPS-197 vectors and an independent key schedule.
module tb_aes128_inv_cipher_core;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_LK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_LK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  int   ksel    = 0;
  logic [127:0] rk_tab [0:1][0:10];
  logic [127:0] exp_q [$];

  aes128_inv_cipher_core_if ifc ();

  always #5 clk = ~clk;

  assign ifc.round_key = rk_tab[ksel][ifc.round_num];

  aes128_inv_cipher_core dut (
    .clk_sys        (clk),
    .rst            (rst),
    .cipher_text    (ifc.cipher_text),
    .last_key       (ifc.last_key),
    .round_key      (ifc.round_key),
    .decipher_en    (ifc.decipher_en),
    .plain_text     (ifc.plain_text),
    .decipher_ready (ifc.decipher_ready),
    .round_num      (ifc.round_num),
    .rkey_en        (ifc.rkey_en)
`ifdef AES128_INV_DONE_PULSE_EN
    ,
    .decipher_done  (ifc.decipher_done)
`endif
  );

`ifndef AES128_INV_DONE_PULSE_EN
  assign ifc.decipher_done = 1'b0;
`endif

  // Done-pulse monitor: counts pulses and any cycle where done disagrees with a ready rise.
  logic mon_en   = 1'b0;
  logic prev_rdy = 1'b1;
  int   pulses   = 0;
  int   align_err = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (ifc.decipher_done === 1'b1) pulses <= pulses + 1;
      if (ifc.decipher_done !== (ifc.decipher_ready && !prev_rdy)) align_err <= align_err + 1;
    end
    prev_rdy <= ifc.decipher_ready;
  end

  // Carry-less product then reduction, independent of the design's shift-and-add.
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc;
    acc = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ ({8'h00, a} << i);
    for (int i = 14; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
    return acc[7:0];
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (tb_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic expand_key(input int sel, input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])}
            ^ {rcon, 24'h0};
        rcon = tb_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called at a negedge; the following rising edge samples the start request.
  task automatic start_block(input logic [127:0] ct, input logic [127:0] lk, input int sel,
                             input logic [127:0] exp);
    ksel = sel;
    ifc.cipher_text = ct;
    ifc.last_key    = lk;
    ifc.decipher_en = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    ifc.decipher_en = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (ifc.decipher_ready !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic test_reset();
    ifc.decipher_en = 1'b0;
    ifc.cipher_text = '0;
    ifc.last_key    = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (ifc.decipher_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", ifc.decipher_ready); else n_pass++;
    n_total++; if (ifc.round_num !== 4'd0) $display("FAIL rst_round: got %0d expected 0", ifc.round_num); else n_pass++;
    n_total++; if (ifc.plain_text !== 128'h0) $display("FAIL rst_pt: got %h expected 0", ifc.plain_text); else n_pass++;
    n_total++; if (ifc.rkey_en !== 1'b0) $display("FAIL rst_rkey_en: got %b expected 0", ifc.rkey_en); else n_pass++;
`ifdef AES128_INV_DONE_PULSE_EN
    n_total++; if (ifc.decipher_done !== 1'b0) $display("FAIL rst_done: got %b expected 0", ifc.decipher_done); else n_pass++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_c1_trace();
    int cnt;
    logic [127:0] exp;
    start_block(C1_CT, C1_LK, 0, C1_PT);
    n_total++; if (ifc.decipher_ready !== 1'b0) $display("FAIL c1_accept: got ready %b expected 0", ifc.decipher_ready); else n_pass++;
    cnt = 0;
    while (ifc.decipher_ready !== 1'b1 && cnt < 40) begin
      n_total++; if (ifc.round_num !== 4'(9 - cnt)) $display("FAIL c1_round_num: got %0d expected %0d", ifc.round_num, 4'(9 - cnt)); else n_pass++;
      n_total++; if (ifc.rkey_en !== 1'b1) $display("FAIL c1_rkey_en_busy: got %b expected 1", ifc.rkey_en); else n_pass++;
      @(negedge clk);
      cnt++;
    end
    n_total++; if (cnt !== 10) $display("FAIL c1_latency: got %0d expected 10", cnt); else n_pass++;
    n_total++; if (ifc.rkey_en !== 1'b0) $display("FAIL c1_rkey_en_idle: got %b expected 0", ifc.rkey_en); else n_pass++;
    n_total++;
    if (exp_q.size() == 0) $display("FAIL c1_result: got empty scoreboard expected one entry");
    else begin
      exp = exp_q.pop_front();
      if (ifc.plain_text !== exp) $display("FAIL c1_result: got %h expected %h", ifc.plain_text, exp); else n_pass++;
    end
    repeat (3) begin
      ifc.cipher_text = {4{$urandom()}};
      ifc.last_key    = {4{$urandom()}};
      @(negedge clk);
    end
    n_total++; if (ifc.plain_text !== C1_PT) $display("FAIL idle_hold_pt: got %h expected %h", ifc.plain_text, C1_PT); else n_pass++;
    n_total++; if (ifc.round_num !== 4'd0) $display("FAIL idle_hold_round: got %0d expected 0", ifc.round_num); else n_pass++;
    n_total++; if (ifc.decipher_ready !== 1'b1) $display("FAIL idle_hold_ready: got %b expected 1", ifc.decipher_ready); else n_pass++;
  endtask

  task automatic test_fips_b();
    int cnt;
    logic [127:0] exp;
    start_block(B_CT, B_LK, 1, B_PT);
    wait_ready(cnt);
    n_total++; if (cnt !== 10) $display("FAIL b_latency: got %0d expected 10", cnt); else n_pass++;
    n_total++;
    if (exp_q.size() == 0) $display("FAIL b_result: got empty scoreboard expected one entry");
    else begin
      exp = exp_q.pop_front();
      if (ifc.plain_text !== exp) $display("FAIL b_result: got %h expected %h", ifc.plain_text, exp); else n_pass++;
    end
  endtask

  task automatic test_ignore_en();
    int cnt;
    logic [127:0] exp;
    start_block(C1_CT, C1_LK, 0, C1_PT);
    ifc.cipher_text = B_CT;
    ifc.last_key    = B_LK;
    cnt = 0;
    while (ifc.decipher_ready !== 1'b1 && cnt < 40) begin
      ifc.decipher_en = (cnt == 2 || cnt == 9);
      @(negedge clk);
      cnt++;
    end
    ifc.decipher_en = 1'b0;
    n_total++; if (cnt !== 10) $display("FAIL ignore_latency: got %0d expected 10", cnt); else n_pass++;
    n_total++;
    if (exp_q.size() == 0) $display("FAIL ignore_result: got empty scoreboard expected one entry");
    else begin
      exp = exp_q.pop_front();
      if (ifc.plain_text !== exp) $display("FAIL ignore_result: got %h expected %h", ifc.plain_text, exp); else n_pass++;
    end
    @(negedge clk);
    n_total++; if (ifc.decipher_ready !== 1'b1) $display("FAIL ignore_no_restart: got ready %b expected 1", ifc.decipher_ready); else n_pass++;
    n_total++; if (ifc.plain_text !== C1_PT) $display("FAIL ignore_pt_hold: got %h expected %h", ifc.plain_text, C1_PT); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int cnt;
    logic [127:0] exp;
    start_block(C1_CT, C1_LK, 0, C1_PT);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    n_total++; if (ifc.decipher_ready !== 1'b1) $display("FAIL abort_ready: got %b expected 1", ifc.decipher_ready); else n_pass++;
    n_total++; if (ifc.plain_text !== 128'h0) $display("FAIL abort_pt: got %h expected 0", ifc.plain_text); else n_pass++;
    n_total++; if (ifc.round_num !== 4'd0) $display("FAIL abort_round: got %0d expected 0", ifc.round_num); else n_pass++;
    n_total++; if (ifc.rkey_en !== 1'b0) $display("FAIL abort_rkey_en: got %b expected 0", ifc.rkey_en); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    start_block(C1_CT, C1_LK, 0, C1_PT);
    n_total++; if (ifc.decipher_ready !== 1'b0) $display("FAIL abort_restart_accept: got ready %b expected 0", ifc.decipher_ready); else n_pass++;
    wait_ready(cnt);
    n_total++; if (cnt !== 10) $display("FAIL abort_rerun_latency: got %0d expected 10", cnt); else n_pass++;
    n_total++;
    if (exp_q.size() == 0) $display("FAIL abort_rerun_result: got empty scoreboard expected one entry");
    else begin
      exp = exp_q.pop_front();
      if (ifc.plain_text !== exp) $display("FAIL abort_rerun_result: got %h expected %h", ifc.plain_text, exp); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    logic [127:0] exp;
    mon_en = 1'b1;
    start_block(C1_CT, C1_LK, 0, C1_PT);
    wait_ready(cnt);
    n_total++; if (cnt !== 10) $display("FAIL b2b_first_latency: got %0d expected 10", cnt); else n_pass++;
    n_total++;
    if (exp_q.size() == 0) $display("FAIL b2b_first_result: got empty scoreboard expected one entry");
    else begin
      exp = exp_q.pop_front();
      if (ifc.plain_text !== exp) $display("FAIL b2b_first_result: got %h expected %h", ifc.plain_text, exp); else n_pass++;
    end
    start_block(B_CT, B_LK, 1, B_PT);
    wait_ready(cnt);
    n_total++; if (cnt !== 10) $display("FAIL b2b_second_latency: got %0d expected 10", cnt); else n_pass++;
    n_total++;
    if (exp_q.size() == 0) $display("FAIL b2b_second_result: got empty scoreboard expected one entry");
    else begin
      exp = exp_q.pop_front();
      if (ifc.plain_text !== exp) $display("FAIL b2b_second_result: got %h expected %h", ifc.plain_text, exp); else n_pass++;
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
`ifdef AES128_INV_DONE_PULSE_EN
    n_total++; if (pulses !== 2) $display("FAIL done_pulse_count: got %0d expected 2", pulses); else n_pass++;
    n_total++; if (align_err !== 0) $display("FAIL done_alignment: got %0d misaligned cycles expected 0", align_err); else n_pass++;
`endif
    n_total++; if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    expand_key(0, C1_KEY);
    expand_key(1, B_KEY);
    test_reset();
    test_c1_trace();
    test_fips_b();
    test_ignore_en();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
